// File: rtl/eth_xbar_sched.sv
// 2x2 crossbar scheduler: per-egress round-robin grant from show-ahead ingress queues, invalid dests dropped.
// Grant in cycle N shows on outo_valid/outo_data in N+1; an egress holding an unaccepted packet takes no grant.
module eth_xbar_sched #(
  parameter int          PKT_WIDTH  = 130,
  parameter logic [31:0] PORT0_ADDR = 32'hABCD,
  parameter logic [31:0] PORT1_ADDR = 32'hEFEF,
  parameter int          DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in0_empty,
  input  logic [PKT_WIDTH-1:0]  in0_data,
  output logic                  in0_rd_en,
  input  logic                  in1_empty,
  input  logic [PKT_WIDTH-1:0]  in1_data,
  output logic                  in1_rd_en,
  output logic                  out0_valid,
  output logic [PKT_WIDTH-1:0]  out0_data,
  input  logic                  out0_ready,
  output logic                  out1_valid,
  output logic [PKT_WIDTH-1:0]  out1_data,
  input  logic                  out1_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  drop_pulse
);

  logic [31:0]           dest0, dest1;
  logic [1:0]            hit_p0, hit_p1, bad;
  logic [1:0]            gnt_p0, gnt_p1;
  logic                  free0, free1;
  logic                  rr_0, rr_1;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [DROP_CNT_W-1:0] drop_nxt;

  // Two requesters share an egress: the pointer picks the winner, else the lone requester wins.
  function automatic logic [1:0] arb(input logic [1:0] req, input logic rr, input logic free);
    if (!free)
      return 2'b00;
    else if (req == 2'b11)
      return rr ? 2'b10 : 2'b01;
    else
      return req;
  endfunction

  assign dest0 = in0_data[32:1];
  assign dest1 = in1_data[32:1];
  assign free0 = !out0_valid || out0_ready;
  assign free1 = !out1_valid || out1_ready;

  // Port 1 match excludes port 0 so an input can never be granted twice in a cycle.
  always_comb begin
    hit_p0[0] = !in0_empty && (dest0 == PORT0_ADDR);
    hit_p0[1] = !in1_empty && (dest1 == PORT0_ADDR);
    hit_p1[0] = !in0_empty && (dest0 == PORT1_ADDR) && (dest0 != PORT0_ADDR);
    hit_p1[1] = !in1_empty && (dest1 == PORT1_ADDR) && (dest1 != PORT0_ADDR);
    bad[0]    = !in0_empty && (dest0 != PORT0_ADDR) && (dest0 != PORT1_ADDR);
    bad[1]    = !in1_empty && (dest1 != PORT0_ADDR) && (dest1 != PORT1_ADDR);
  end

  assign gnt_p0 = arb(hit_p0, rr_0, free0);
  assign gnt_p1 = arb(hit_p1, rr_1, free1);

  assign in0_rd_en = rstn && (gnt_p0[0] || gnt_p1[0] || bad[0]);
  assign in1_rd_en = rstn && (gnt_p0[1] || gnt_p1[1] || bad[1]);

  always_comb begin
    drop_sum = {1'b0, drop_cnt} + {{DROP_CNT_W{1'b0}}, bad[0]} + {{DROP_CNT_W{1'b0}}, bad[1]};
    drop_nxt = drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out1_valid <= 1'b0;
      out1_data  <= '0;
      rr_0       <= 1'b0;
      rr_1       <= 1'b0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      if (|gnt_p0) begin
        out0_valid <= 1'b1;
        out0_data  <= gnt_p0[1] ? in1_data : in0_data;
        rr_0       <= gnt_p0[0];
      end else if (out0_ready) begin
        out0_valid <= 1'b0;
      end
      if (|gnt_p1) begin
        out1_valid <= 1'b1;
        out1_data  <= gnt_p1[1] ? in1_data : in0_data;
        rr_1       <= gnt_p1[0];
      end else if (out1_ready) begin
        out1_valid <= 1'b0;
      end
      drop_cnt   <= drop_nxt;
      drop_pulse <= |bad;
    end
  end

endmodule

// File: tb/tb_eth_xbar_sched.sv
// Bench for eth_xbar_sched: queue-modelled ingress, per-egress expected-packet scoreboards.
module tb_eth_xbar_sched;
  localparam int          PW  = 130;
  localparam logic [31:0] A0  = 32'hABCD;
  localparam logic [31:0] A1  = 32'hEFEF;
  localparam logic [31:0] BAD = 32'h1234;

  logic          clk, rstn;
  logic          in0_empty, in1_empty, in0_rd_en, in1_rd_en;
  logic [PW-1:0] in0_data, in1_data, out0_data, out1_data;
  logic          out0_valid, out1_valid, out0_ready, out1_ready;
  logic [15:0]   drop_cnt;
  logic          drop_pulse;

  logic [PW-1:0] q0[$], q1[$], exp0[$], exp1[$];
  int n_chk = 0;
  int n_fail = 0;

  eth_xbar_sched dut (
    .clk(clk), .rstn(rstn),
    .in0_empty(in0_empty), .in0_data(in0_data), .in0_rd_en(in0_rd_en),
    .in1_empty(in1_empty), .in1_data(in1_data), .in1_rd_en(in1_rd_en),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
    .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] dest, input logic [31:0] tag);
    return {1'b1, ~tag, tag ^ 32'h5A5A_0000, tag, dest, 1'b1};
  endfunction

  task automatic upd_in();
    in0_empty = (q0.size() == 0);
    in1_empty = (q1.size() == 0);
    in0_data  = in0_empty ? '0 : q0[0];
    in1_data  = in1_empty ? '0 : q1[0];
  endtask

  task automatic push0(input logic [PW-1:0] p);
    q0.push_back(p);
    upd_in();
  endtask

  task automatic push1(input logic [PW-1:0] p);
    q1.push_back(p);
    upd_in();
  endtask

  // One clock: check pop rules and handshakes before the edge, then retire popped heads.
  task automatic cycle();
    logic          rd0, rd1;
    logic [PW-1:0] dummy;
    #1;
    rd0 = in0_rd_en;
    rd1 = in1_rd_en;
    if (in0_empty) chk("rd0_while_empty", PW'(rd0), PW'(0));
    if (in1_empty) chk("rd1_while_empty", PW'(rd1), PW'(0));
    if (out0_valid && out0_ready) begin
      if (exp0.size() == 0) chk("out0_extra", PW'(out0_valid), PW'(0));
      else chk("out0_data", out0_data, exp0.pop_front());
    end
    if (out1_valid && out1_ready) begin
      if (exp1.size() == 0) chk("out1_extra", PW'(out1_valid), PW'(0));
      else chk("out1_data", out1_data, exp1.pop_front());
    end
    @(posedge clk);
    #1;
    if (rd0 && q0.size() > 0) dummy = q0.pop_front();
    if (rd1 && q1.size() > 0) dummy = q1.pop_front();
    upd_in();
  endtask

  task automatic drain();
    int n;
    n = 0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    while ((q0.size() > 0 || q1.size() > 0 || exp0.size() > 0 || exp1.size() > 0 ||
            out0_valid || out1_valid) && n < 40) begin
      cycle();
      n++;
    end
    chk("drain_timeout", PW'(n >= 40), PW'(0));
    chk("drain_left", PW'(exp0.size() + exp1.size()), PW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p, hold, pb;
    rstn = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    upd_in();
    cycle();
    cycle();
    chk("rst_v0", PW'(out0_valid), PW'(0));
    chk("rst_v1", PW'(out1_valid), PW'(0));
    chk("rst_d0", out0_data, '0);
    chk("rst_d1", out1_data, '0);
    chk("rst_cnt", PW'(drop_cnt), PW'(0));
    chk("rst_pulse", PW'(drop_pulse), PW'(0));
    rstn = 1'b1;

    // single route in0 -> port 1
    p = mk(A1, 32'h11);
    push0(p);
    exp1.push_back(p);
    out1_ready = 1'b1;
    #1;
    chk("single_rd0", PW'(in0_rd_en), PW'(1));
    chk("single_rd1", PW'(in1_rd_en), PW'(0));
    cycle();
    chk("single_v1", PW'(out1_valid), PW'(1));
    chk("single_d1", out1_data, p);
    chk("single_v0", PW'(out0_valid), PW'(0));
    drain();

    // contention on port 0: strict alternation starting with in0
    for (int k = 0; k < 3; k++) begin
      push0(mk(A0, 32'h100 + k));
      push1(mk(A0, 32'h200 + k));
      exp0.push_back(mk(A0, 32'h100 + k));
      exp0.push_back(mk(A0, 32'h200 + k));
    end
    out0_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_rd0", PW'(in0_rd_en), PW'(k % 2 == 0));
      chk("cont_rd1", PW'(in1_rd_en), PW'(k % 2 == 1));
      if (k > 0) chk("cont_b2b", PW'(out0_valid), PW'(1));
      cycle();
    end
    chk("cont_b2b", PW'(out0_valid), PW'(1));
    drain();

    // backpressure on port 0
    hold = mk(A0, 32'h300);
    pb   = mk(A0, 32'h301);
    p    = mk(A0, 32'h302);
    push0(hold);
    push0(p);
    push1(pb);
    exp0.push_back(hold);
    exp0.push_back(pb);
    exp0.push_back(p);
    out0_ready = 1'b0;
    #1;
    chk("bp_first_rd0", PW'(in0_rd_en), PW'(1));
    cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rd0", PW'(in0_rd_en), PW'(0));
      chk("bp_rd1", PW'(in1_rd_en), PW'(0));
      chk("bp_valid", PW'(out0_valid), PW'(1));
      chk("bp_data", out0_data, hold);
      cycle();
    end
    out0_ready = 1'b1;
    #1;
    chk("bp_release_rd1", PW'(in1_rd_en), PW'(1));
    cycle();
    chk("bp_nobubble_v", PW'(out0_valid), PW'(1));
    chk("bp_nobubble_d", out0_data, pb);
    drain();

    // parallel grants to both ports
    push0(mk(A0, 32'h400));
    push1(mk(A1, 32'h401));
    exp0.push_back(mk(A0, 32'h400));
    exp1.push_back(mk(A1, 32'h401));
    #1;
    chk("par_rd0", PW'(in0_rd_en), PW'(1));
    chk("par_rd1", PW'(in1_rd_en), PW'(1));
    cycle();
    chk("par_v0", PW'(out0_valid), PW'(1));
    chk("par_v1", PW'(out1_valid), PW'(1));
    drain();

    // invalid destination drop and counter saturation
    chk("drop_cnt0", PW'(drop_cnt), PW'(0));
    push1(mk(BAD, 32'h500));
    #1;
    chk("drop_rd1", PW'(in1_rd_en), PW'(1));
    cycle();
    chk("drop_v0", PW'(out0_valid), PW'(0));
    chk("drop_v1", PW'(out1_valid), PW'(0));
    chk("drop_cnt1", PW'(drop_cnt), PW'(1));
    chk("drop_pulse1", PW'(drop_pulse), PW'(1));
    cycle();
    chk("drop_pulse0", PW'(drop_pulse), PW'(0));
    for (int k = 0; k < 32766; k++) begin
      push0(mk(BAD, k));
      push1(mk(BAD + 1, k));
      cycle();
    end
    chk("drop_cnt_fffd", PW'(drop_cnt), PW'(16'hFFFD));
    push0(mk(BAD, 32'h600));
    cycle();
    chk("drop_cnt_fffe", PW'(drop_cnt), PW'(16'hFFFE));
    push0(mk(BAD, 32'h601));
    push1(mk(BAD, 32'h602));
    cycle();
    chk("drop_sat_add2", PW'(drop_cnt), PW'(16'hFFFF));
    push1(mk(BAD, 32'h603));
    cycle();
    chk("drop_sat_hold", PW'(drop_cnt), PW'(16'hFFFF));
    chk("drop_sat_pulse", PW'(drop_pulse), PW'(1));
    cycle();

    // reset while port 1 holds a packet; both rr pointers are 1 beforehand
    out1_ready = 1'b0;
    p = mk(A1, 32'h700);
    push0(p);
    exp1.push_back(p);
    cycle();
    chk("mid_v1", PW'(out1_valid), PW'(1));
    push1(mk(A0, 32'h701));
    rstn = 1'b0;
    #1;
    chk("rst_rd1_forced", PW'(in1_rd_en), PW'(0));
    cycle();
    exp1.delete();
    chk("mid_v0", PW'(out0_valid), PW'(0));
    chk("mid_v1_clr", PW'(out1_valid), PW'(0));
    chk("mid_d0", out0_data, '0);
    chk("mid_d1", out1_data, '0);
    chk("mid_cnt", PW'(drop_cnt), PW'(0));
    chk("mid_pulse", PW'(drop_pulse), PW'(0));
    rstn = 1'b1;
    push0(mk(A0, 32'h702));
    exp0.push_back(mk(A0, 32'h702));
    exp0.push_back(mk(A0, 32'h701));
    out0_ready = 1'b1;
    #1;
    chk("mid_rr0_rd0", PW'(in0_rd_en), PW'(1));
    chk("mid_rr0_rd1", PW'(in1_rd_en), PW'(0));
    drain();
    push0(mk(A1, 32'h710));
    push1(mk(A1, 32'h711));
    exp1.push_back(mk(A1, 32'h710));
    exp1.push_back(mk(A1, 32'h711));
    #1;
    chk("mid_rr1_rd0", PW'(in0_rd_en), PW'(1));
    chk("mid_rr1_rd1", PW'(in1_rd_en), PW'(0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
